// File: rtl/surf_wb_router.sv
// surf_wb_router: registered Wishbone router from one master to N_SURF targets with per-transaction timeout
module surf_wb_router #(
    parameter int N_SURF  = 7,
    parameter int SEL_W   = 3,
    parameter int ADR_W   = 22,
    parameter int TIMEOUT = 1023
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic                s_cyc_i,
    input  logic                s_stb_i,
    input  logic                s_we_i,
    input  logic [ADR_W-1:0]    s_adr_i,
    input  logic [31:0]         s_dat_i,
    input  logic [3:0]          s_sel_i,
    input  logic [SEL_W-1:0]    s_select_i,
    output logic [31:0]         s_dat_o,
    output logic                s_ack_o,
    output logic                s_err_o,
    output logic                s_rty_o,
    output logic [N_SURF-1:0]   m_cyc_o,
    output logic [N_SURF-1:0]   m_stb_o,
    output logic                m_we_o,
    output logic [ADR_W-1:0]    m_adr_o,
    output logic [31:0]         m_dat_o,
    output logic [3:0]          m_sel_o,
    input  logic [32*N_SURF-1:0] m_dat_i,
    input  logic [N_SURF-1:0]   m_ack_i,
    input  logic [N_SURF-1:0]   m_err_i,
    input  logic [N_SURF-1:0]   m_rty_i,
    output logic [N_SURF-1:0]   timeout_o,
    input  logic                err_rst_i,
    output logic                busy_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;
    state_t state, nxt;
    logic [N_SURF-1:0] ch_oh, sel_oh;
    logic [CW-1:0] cnt;
    logic [31:0] rd_dat;
    logic req, legal, hit_ack, hit_err, hit_rty, hit, tmo, tmo_set;

    assign req     = s_cyc_i & s_stb_i;
    assign legal   = (s_select_i != '0) && (s_select_i <= SEL_W'(N_SURF));
    assign sel_oh  = N_SURF'(1) << (s_select_i - SEL_W'(1));
    assign hit_ack = |(m_ack_i & ch_oh);
    assign hit_err = |(m_err_i & ch_oh);
    assign hit_rty = |(m_rty_i & ch_oh);
    assign hit     = hit_ack | hit_err | hit_rty;
    assign tmo     = cnt == CW'(TIMEOUT - 1);
    assign tmo_set = (state == ACTIVE) && s_cyc_i && !hit && tmo;
    assign busy_o  = state != IDLE;

    always_comb begin
        rd_dat = '0;
        for (int k = 0; k < N_SURF; k++)
            if (ch_oh[k]) rd_dat = m_dat_i[32*k +: 32];
    end

    always_comb begin
        nxt = state == IDLE   ? (req ? (legal ? ACTIVE : RESP) : IDLE) :
              state == ACTIVE ? (!s_cyc_i ? IDLE : (hit || tmo) ? RESP : ACTIVE) :
                                IDLE;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) state <= IDLE;
        else state <= nxt;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            ch_oh     <= '0;
            cnt       <= '0;
            m_cyc_o   <= '0;
            m_stb_o   <= '0;
            m_we_o    <= 1'b0;
            m_adr_o   <= '0;
            m_dat_o   <= '0;
            m_sel_o   <= '0;
            s_dat_o   <= '0;
            s_ack_o   <= 1'b0;
            s_err_o   <= 1'b0;
            s_rty_o   <= 1'b0;
            timeout_o <= '0;
        end else begin
            s_ack_o   <= 1'b0;
            s_err_o   <= 1'b0;
            s_rty_o   <= 1'b0;
            timeout_o <= (err_rst_i ? '0 : timeout_o) | (tmo_set ? ch_oh : '0);
            if (state == IDLE && req) begin
                if (legal) begin
                    ch_oh   <= sel_oh;
                    m_cyc_o <= sel_oh;
                    m_stb_o <= sel_oh;
                    m_we_o  <= s_we_i;
                    m_adr_o <= s_adr_i;
                    m_dat_o <= s_dat_i;
                    m_sel_o <= s_sel_i;
                    cnt     <= '0;
                end else begin
                    s_err_o <= 1'b1;
                    s_dat_o <= '0;
                end
            end else if (state == ACTIVE) begin
                cnt <= cnt + CW'(1);
                if (!s_cyc_i || hit || tmo) begin
                    m_cyc_o <= '0;
                    m_stb_o <= '0;
                end
                // a response arriving on the timeout cycle takes precedence over the timeout
                if (s_cyc_i && (hit || tmo)) begin
                    s_err_o <= hit_err || !hit;
                    s_rty_o <= !hit_err && hit_rty;
                    s_ack_o <= !hit_err && !hit_rty && hit_ack;
                    s_dat_o <= (!hit_err && !hit_rty && hit_ack) ? rd_dat : '0;
                end
            end
        end
    end
endmodule
